// File: rtl/timer_pkg.sv
// Shared types and default parameters for the tick-driven countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_RUN   = 2'd1,
        T_PAUSE = 2'd2
    } timer_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 5;
    localparam int DEF_MAX_COUNT   = 20;
    localparam int DEF_WARN_THRESH = 3;

endpackage

// File: rtl/edge_sync_detect.sv
// Synchronises a foreign-domain square wave and emits a registered one-cycle
// pulse on each rising edge; falling edges produce nothing.
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick_q;

    // Rise-to-pulse latency is SYNC_STAGES+1 clk edges: sync chain, then the compare flop.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            tick_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/tick_countdown_timer.sv
// Seconds countdown driven by ticks from the synchronised slow clock:
// start/pause/abort control, warning window, HUD blink and a one-cycle expiry pulse.
module tick_countdown_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 5,
    parameter int MAX_COUNT   = 20,
    parameter int WARN_THRESH = 3
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             slow_clk_in,
    input  logic             start,
    input  logic [CNT_W-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
    output logic             tick,
    output logic [CNT_W-1:0] time_left,
    output logic             running,
    output logic             warning,
    output logic             blink,
    output logic             expired
);
    import timer_pkg::*;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] WARN_CNT = CNT_W'(WARN_THRESH);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_clamped;
    logic             blink_q, blink_d;
    logic             exp_q, exp_d;
    logic             clear_blink;
    logic             warn_d;

    edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk      (clk),
        .resetN   (resetN),
        .async_in (slow_clk_in),
        .tick     (tick)
    );

    assign load_clamped = (load_value > MAX_CNT) ? MAX_CNT : load_value;

    // start and abort are single-cycle requests with no ready: they are
    // accepted in the cycle they are high, abort over start over pause over tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_d       = 1'b0;
        clear_blink = 1'b0;
        if (abort) begin
            state_d     = T_IDLE;
            cnt_d       = '0;
            clear_blink = 1'b1;
        end else if (start) begin
            clear_blink = 1'b1;
            cnt_d       = load_clamped;
            if (load_clamped != '0) begin
                state_d = T_RUN;
            end else begin
                state_d = T_IDLE;
                exp_d   = 1'b1;
            end
        end else begin
            case (state_q)
                T_RUN: begin
                    if (pause) begin
                        state_d = T_PAUSE;
                    end else if (tick && (cnt_q != '0)) begin
                        if (cnt_q == CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = T_IDLE;
                            exp_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                T_PAUSE: begin
                    if (!pause) state_d = T_RUN;
                end
                T_IDLE:  state_d = T_IDLE;
                default: state_d = T_IDLE;
            endcase
        end

        // Blink only lives inside the warning window of the next state.
        warn_d = (state_d != T_IDLE) && (cnt_d != '0) && (cnt_d <= WARN_CNT);
        if (clear_blink || !warn_d) begin
            blink_d = 1'b0;
        end else if (tick && warning) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            exp_q   <= exp_d;
        end
    end

    assign time_left = cnt_q;
    assign running   = (state_q != T_IDLE);
    assign warning   = (state_q != T_IDLE) && (cnt_q != '0) && (cnt_q <= WARN_CNT);
    assign blink     = blink_q;
    assign expired   = exp_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Table-driven bench for tick_countdown_timer: one record per clk cycle of
// inputs and the outputs expected just after that edge, plus a reset sequence.
module tb_tick_countdown_timer;

    logic       clk;
    logic       resetN;
    logic       slow_clk_in;
    logic       start;
    logic [4:0] load_value;
    logic       pause;
    logic       abort;
    logic       tick;
    logic [4:0] time_left;
    logic       running;
    logic       warning;
    logic       blink;
    logic       expired;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       s;
        logic       st;
        logic [4:0] ld;
        logic       p;
        logic       a;
        logic       tk;
        logic [4:0] tl;
        logic       rn;
        logic       wn;
        logic       bl;
        logic       ex;
    } vec_t;

    vec_t vecs[$];

    tick_countdown_timer #(
        .SYNC_STAGES (2),
        .CNT_W       (5),
        .MAX_COUNT   (20),
        .WARN_THRESH (3)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .slow_clk_in (slow_clk_in),
        .start       (start),
        .load_value  (load_value),
        .pause       (pause),
        .abort       (abort),
        .tick        (tick),
        .time_left   (time_left),
        .running     (running),
        .warning     (warning),
        .blink       (blink),
        .expired     (expired)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // vector table builders
    task automatic add(input logic s, input logic st, input logic [4:0] ld,
                       input logic p, input logic a, input logic tk,
                       input logic [4:0] tl, input logic rn, input logic wn,
                       input logic bl, input logic ex);
        vec_t v;
        v.s = s; v.st = st; v.ld = ld; v.p = p; v.a = a;
        v.tk = tk; v.tl = tl; v.rn = rn; v.wn = wn; v.bl = bl; v.ex = ex;
        vecs.push_back(v);
    endtask

    // One slow period (high 2, low 2): tick shows in the 3rd row, its effect in the 4th.
    task automatic per(input logic p,
                       input logic [4:0] tl_b, input logic rn_b, input logic wn_b, input logic bl_b,
                       input logic [4:0] tl_a, input logic rn_a, input logic wn_a, input logic bl_a,
                       input logic ex_a);
        add(1, 0, 0, p, 0, 0, tl_b, rn_b, wn_b, bl_b, 0);
        add(1, 0, 0, p, 0, 0, tl_b, rn_b, wn_b, bl_b, 0);
        add(0, 0, 0, p, 0, 1, tl_b, rn_b, wn_b, bl_b, 0);
        add(0, 0, 0, p, 0, 0, tl_a, rn_a, wn_a, bl_a, ex_a);
    endtask

    // scoreboard compare
    task automatic check(input string name, input logic tk, input logic [4:0] tl,
                         input logic rn, input logic wn, input logic bl, input logic ex);
        logic [9:0] act;
        logic [9:0] req;
        act = {tick, time_left, running, warning, blink, expired};
        req = {tk, tl, rn, wn, bl, ex};
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got tick=%b time_left=%0d running=%b warning=%b blink=%b expired=%b, need tick=%b time_left=%0d running=%b warning=%b blink=%b expired=%b",
                     name, tick, time_left, running, warning, blink, expired,
                     tk, tl, rn, wn, bl, ex);
        end
    endtask

    initial begin
        // idle, tick latency, falling edge ignored
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load 5 and count to expiry
        add(0, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0);
        per(0, 5, 1, 0, 0, 4, 1, 0, 0, 0);
        per(0, 4, 1, 0, 0, 3, 1, 1, 0, 0);
        per(0, 3, 1, 1, 0, 2, 1, 1, 1, 0);
        per(0, 2, 1, 1, 1, 1, 1, 1, 0, 0);
        per(0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // tick while idle changes nothing
        per(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // clamp, then restart with zero load
        add(0, 1, 25, 0, 0, 0, 20, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // pause holds across three ticks
        add(0, 1, 4, 0, 0, 0, 4, 1, 0, 0, 0);
        per(1, 4, 1, 0, 0, 4, 1, 0, 0, 0);
        per(1, 4, 1, 0, 0, 4, 1, 0, 0, 0);
        per(1, 4, 1, 0, 0, 4, 1, 0, 0, 0);
        per(0, 4, 1, 0, 0, 3, 1, 1, 0, 0);
        per(0, 3, 1, 1, 0, 2, 1, 1, 1, 0);
        // abort at 2 with blink high, no expiry
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // start and abort together: abort wins
        add(0, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        resetN      = 1'b0;
        slow_clk_in = 1'b0;
        start       = 1'b0;
        load_value  = '0;
        pause       = 1'b0;
        abort       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 0, 0, 0, 0, 0, 0);
        #2 resetN = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;

        // driver: apply record, clock it, compare
        foreach (vecs[i]) begin
            slow_clk_in = vecs[i].s;
            start       = vecs[i].st;
            load_value  = vecs[i].ld;
            pause       = vecs[i].p;
            abort       = vecs[i].a;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].tk, vecs[i].tl, vecs[i].rn,
                  vecs[i].wn, vecs[i].bl, vecs[i].ex);
        end

        // asynchronous reset in the middle of a count
        start      = 1'b1;
        load_value = 5'd7;
        @(posedge clk);
        #1;
        check("load7", 0, 7, 1, 0, 0, 0);
        start = 1'b0;
        #2 resetN = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 resetN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset%0d", k), 0, 0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
